// File: rtl/spi_pkg.sv
// Shared definitions for the arbitrated SPI master: FSM state type,
// default sizing and the round-robin index helper.
package spi_pkg;

    localparam int DW_DEF   = 8;
    localparam int NREQ_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_st_t;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/spi_arb_master_rr_arb.sv
// Round-robin arbiter. The grant is combinational from the current
// pointer; the pointer moves one past the winner when the grant is taken.
module rr_arb
    import spi_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk100,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] probe;
    logic          found;

    // Walk the ring starting at the pointer; the first active request wins.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        probe   = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            probe = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[probe]) begin
                found        = 1'b1;
                gnt[probe]   = 1'b1;
                win_idx      = probe;
            end
        end
    end

    // Pointer update: search restarts just after the requester last served.
    always_ff @(posedge clk100) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= PW'(rr_next(int'(win_idx), NREQ));
        end
    end

endmodule

// File: rtl/spi_arb_master.sv
// Multi-requester SPI mode-0 master. Each requester owns one chip select;
// a round-robin arbiter picks the next requester while idle, its byte is
// shifted out MSB first while the slave's reply is shifted in from miso_i.
module spi_arb_master
    import spi_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DW       = DW_DEF,
    parameter int HALF_DIV = 4
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic [DW-1:0]      rdata_o,
    output logic               busy_o,
    output logic               sclk_o,
    output logic               mosi_o,
    input  logic               miso_i,
    output logic [NREQ-1:0]    csn_o
);

    localparam int             BW       = $clog2(DW + 1);
    localparam logic [7:0]     DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DW);
    localparam logic [BW-1:0]  BIT_PEN  = BW'(DW - 1);

    spi_st_t          state;
    logic [7:0]       div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [NREQ-1:0]  arb_gnt;
    logic [NREQ-1:0]  sel;
    logic [DW-1:0]    wsel;
    logic [DW-1:0]    tx_sr;
    logic [DW-1:0]    tx_next;
    logic [DW-1:0]    rx_sr;
    logic             miso_s1;
    logic             miso_s2;
    logic             div_wrap;
    logic             grant_now;
    logic             fall_now;

    rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .clk100 (clk100),
        .rst    (rst),
        .req    (req_i),
        .adv    (grant_now),
        .gnt    (arb_gnt)
    );

    // The grant is decided in the IDLE cycle itself; reset masks it so no
    // requester sees a grant whose capture is being discarded.
    assign grant_now = (state == ST_IDLE) && !rst && (|req_i);
    assign gnt_o     = grant_now ? arb_gnt : '0;
    assign busy_o    = grant_now || (state != ST_IDLE);
    assign div_wrap  = (div_cnt == DIV_LAST);
    assign fall_now  = (state == ST_SHIFT) && div_wrap && sclk_o;
    assign tx_next   = tx_sr << 1;

    // Select the winning requester's transmit byte (arb_gnt is one-hot).
    always_comb begin
        wsel = '0;
        for (int k = 0; k < NREQ; k++) begin
            wsel = wsel | (wdata_i[k*DW +: DW] & {DW{arb_gnt[k]}});
        end
    end

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk100) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= miso_i;
            miso_s2 <= miso_s1;
        end
    end

    // Shift registers: load on grant; at the end of each SCLK high phase
    // move the transmit byte on and take in the synchronized MISO bit.
    always_ff @(posedge clk100) begin
        if (grant_now) begin
            tx_sr <= wsel;
        end else if (fall_now) begin
            tx_sr <= tx_next;
            rx_sr <= {rx_sr[DW-2:0], miso_s2};
        end
    end

    // Transfer sequencer and registered SPI pins.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sel     <= '0;
            csn_o   <= '1;
            sclk_o  <= 1'b0;
            mosi_o  <= 1'b0;
            done_o  <= '0;
            rdata_o <= '0;
        end else begin
            done_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        state   <= ST_SETUP;
                        sel     <= arb_gnt;
                        csn_o   <= ~arb_gnt;
                        mosi_o  <= wsel[DW-1];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        sclk_o  <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (!div_wrap) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (sclk_o) begin
                            // Falling edge: present the next bit unless this
                            // was the last one, in which case bit 0 stays.
                            sclk_o  <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt != BIT_PEN) begin
                                mosi_o <= tx_next[DW-1];
                            end
                        end else if (bit_cnt == BIT_LAST) begin
                            state <= ST_HOLD;
                        end else begin
                            sclk_o <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        csn_o   <= '1;
                        mosi_o  <= 1'b0;
                        done_o  <= sel;
                        rdata_o <= rx_sr;
                        state   <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb_master.sv
// Bench for spi_arb_master: loopback slave on the default instance, a
// pattern-driving slave on a HALF_DIV=2 instance, scoreboard queues fed by
// a negedge monitor, and an always-on SPI protocol watcher.
module tb_spi_arb_master;

    localparam int NREQ = 3;
    localparam int DW   = 8;

    logic               clk100 = 1'b0;
    logic               rst    = 1'b1;
    logic [NREQ-1:0]    req_i  = '0;
    logic [NREQ*DW-1:0] wdata_i = '0;
    logic [NREQ-1:0]    gnt_o, done_o, csn_o;
    logic [DW-1:0]      rdata_o;
    logic               busy_o, sclk_o, mosi_o, miso_i;

    logic [NREQ-1:0]    req2   = '0;
    logic [NREQ*DW-1:0] wdata2 = '0;
    logic [NREQ-1:0]    gnt2, done2, csn2;
    logic [DW-1:0]      rdata2;
    logic               busy2, sclk2, mosi2, miso2;

    always #5 clk100 = ~clk100;

    assign miso_i = mosi_o;

    spi_arb_master #(.NREQ(NREQ), .DW(DW), .HALF_DIV(4)) dut (
        .clk100(clk100), .rst(rst), .req_i(req_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .csn_o(csn_o)
    );

    spi_arb_master #(.NREQ(NREQ), .DW(DW), .HALF_DIV(2)) dut2 (
        .clk100(clk100), .rst(rst), .req_i(req2), .wdata_i(wdata2),
        .gnt_o(gnt2), .done_o(done2), .rdata_o(rdata2), .busy_o(busy2),
        .sclk_o(sclk2), .mosi_o(mosi2), .miso_i(miso2), .csn_o(csn2)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int prot_viol = 0;

    always @(posedge clk100) cyc++;

    // Scoreboard queues
    int             gnt_cyc_q[$];
    logic [NREQ-1:0] gnt_vec_q[$];
    int             done_cyc_q[$];
    logic [NREQ-1:0] done_vec_q[$];
    logic [DW-1:0]  done_dat_q[$];
    logic [DW-1:0]  mosi_q[$];
    logic [NREQ-1:0] csnl_q[$];
    int             exp_idx_q[$];
    logic [DW-1:0]  exp_dat_q[$];

    logic [DW-1:0]   mosi_acc = '0;
    logic [NREQ-1:0] csn_acc  = '0;
    logic            sclk_prev = 1'b0;
    logic            mosi_prev = 1'b0;

    // Monitor + protocol watcher on the default instance
    always @(negedge clk100) begin
        if (!rst) begin
            if (!$onehot0(~csn_o)) begin
                prot_viol++;
                $display("FAIL protocol_csn_onehot: csn_o=%b at cycle %0d", csn_o, cyc);
            end
            if (csn_o == '1 && sclk_o) begin
                prot_viol++;
                $display("FAIL protocol_sclk_idle: sclk_o=1 with csn_o=%b at cycle %0d", csn_o, cyc);
            end
            if (sclk_o && sclk_prev && (mosi_o !== mosi_prev)) begin
                prot_viol++;
                $display("FAIL protocol_mosi_stable: mosi_o changed to %b while sclk high at cycle %0d", mosi_o, cyc);
            end
        end
        if (gnt_o != '0 && !rst) begin
            gnt_cyc_q.push_back(cyc);
            gnt_vec_q.push_back(gnt_o);
            mosi_acc = '0;
            csn_acc  = '0;
        end
        if (csn_o != '1) csn_acc = csn_acc | ~csn_o;
        if (sclk_o && !sclk_prev) mosi_acc = {mosi_acc[DW-2:0], mosi_o};
        if (done_o != '0) begin
            done_cyc_q.push_back(cyc);
            done_vec_q.push_back(done_o);
            done_dat_q.push_back(rdata_o);
            mosi_q.push_back(mosi_acc);
            csnl_q.push_back(csn_acc);
        end
        sclk_prev = sclk_o;
        mosi_prev = mosi_o;
    end

    // Mode-0 slave for the second instance: shifts its pattern out after
    // each SCLK falling edge, reloads while deselected.
    logic [DW-1:0] slave_pat = '0;
    logic [DW-1:0] slave_sr2 = '0;
    logic          sclk2_prev = 1'b0;
    assign miso2 = slave_sr2[DW-1];

    always @(negedge clk100) begin
        if (csn2 == '1) slave_sr2 = slave_pat;
        else if (sclk2_prev && !sclk2) slave_sr2 = slave_sr2 << 1;
        sclk2_prev = sclk2;
    end

    task automatic clear_queues();
        gnt_cyc_q.delete(); gnt_vec_q.delete();
        done_cyc_q.delete(); done_vec_q.delete(); done_dat_q.delete();
        mosi_q.delete(); csnl_q.delete();
        exp_idx_q.delete(); exp_dat_q.delete();
    endtask

    task automatic reset_dut();
        @(posedge clk100); #1;
        rst = 1'b1; req_i = '0; req2 = '0;
        repeat (3) @(posedge clk100);
        #1 rst = 1'b0;
        clear_queues();
    endtask

    task automatic wait_gnt(input int want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk100);
            if (gnt_cyc_q.size() >= want) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk100);
            if (done_cyc_q.size() >= want) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 3'b111;
        repeat (2) @(posedge clk100);
        #1;
        n_total++; if (csn_o !== 3'b111) $display("FAIL reset_csn: got %b want 111", csn_o); else n_pass++;
        n_total++; if (sclk_o !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk_o); else n_pass++;
        n_total++; if (mosi_o !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi_o); else n_pass++;
        n_total++; if (gnt_o !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt_o); else n_pass++;
        n_total++; if (done_o !== 3'b000) $display("FAIL reset_done: got %b want 000", done_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if (rdata_o !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata_o); else n_pass++;
        req_i = '0;
        @(posedge clk100); #1 rst = 1'b0;
        clear_queues();
    endtask

    task automatic test_single();
        bit ok;
        int g, d, ei;
        logic [DW-1:0] ed;
        wdata_i[0*DW +: DW] = 8'hA5;
        exp_idx_q.push_back(0); exp_dat_q.push_back(8'hA5);
        @(posedge clk100); #1 req_i = 3'b001;
        wait_gnt(1, ok);
        if (!ok) begin n_total++; $display("FAIL single_gnt_timeout: got none want gnt"); return; end
        n_total++; if (busy_o !== 1'b1) $display("FAIL single_busy_at_gnt: got %b want 1", busy_o); else n_pass++;
        @(posedge clk100); #1 req_i = '0;
        wait_done(1, ok);
        if (!ok) begin n_total++; $display("FAIL single_done_timeout: got none want done"); return; end
        g = gnt_cyc_q.pop_front(); d = done_cyc_q.pop_front();
        ei = exp_idx_q.pop_front(); ed = exp_dat_q.pop_front();
        n_total++; if (gnt_vec_q[0] !== NREQ'(1 << ei)) $display("FAIL single_gnt_vec: got %b want %b", gnt_vec_q[0], NREQ'(1 << ei)); else n_pass++;
        n_total++; if (done_vec_q[0] !== NREQ'(1 << ei)) $display("FAIL single_done_vec: got %b want %b", done_vec_q[0], NREQ'(1 << ei)); else n_pass++;
        n_total++; if (d - g !== 73) $display("FAIL single_latency: got %0d want 73", d - g); else n_pass++;
        n_total++; if (done_dat_q[0] !== ed) $display("FAIL single_rdata: got %h want %h", done_dat_q[0], ed); else n_pass++;
        n_total++; if (mosi_q[0] !== 8'hA5) $display("FAIL single_mosi_bits: got %h want a5", mosi_q[0]); else n_pass++;
        n_total++; if (csnl_q[0] !== 3'b001) $display("FAIL single_csn_used: got %b want 001", csnl_q[0]); else n_pass++;
        repeat (3) @(posedge clk100); #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_o); else n_pass++;
        n_total++; if (rdata_o !== 8'hA5) $display("FAIL single_rdata_held: got %h want a5", rdata_o); else n_pass++;
        clear_queues();
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev_done;
        reset_dut();
        wdata_i = {8'h33, 8'h22, 8'h11};
        exp_idx_q = '{0, 1, 2, 0};
        exp_dat_q = '{8'h11, 8'h22, 8'h33, 8'h11};
        @(posedge clk100); #1 req_i = 3'b111;
        wait_gnt(4, ok);
        if (!ok) begin n_total++; $display("FAIL rr_gnt_timeout: got %0d want 4 grants", gnt_cyc_q.size()); req_i = '0; return; end
        @(posedge clk100); #1 req_i = '0;
        wait_done(4, ok);
        if (!ok) begin n_total++; $display("FAIL rr_done_timeout: got %0d want 4", done_cyc_q.size()); return; end
        prev_done = 0;
        for (int i = 0; i < 4; i++) begin
            int g, d, ei;
            logic [DW-1:0] ed;
            logic [NREQ-1:0] gv, dv, rd;
            g = gnt_cyc_q.pop_front(); gv = gnt_vec_q.pop_front();
            d = done_cyc_q.pop_front(); dv = done_vec_q.pop_front(); rd = '0;
            ei = exp_idx_q.pop_front(); ed = exp_dat_q.pop_front();
            n_total++; if (gv !== NREQ'(1 << ei)) $display("FAIL rr_order_%0d: got %b want %b", i, gv, NREQ'(1 << ei)); else n_pass++;
            n_total++; if (dv !== NREQ'(1 << ei)) $display("FAIL rr_done_%0d: got %b want %b", i, dv, NREQ'(1 << ei)); else n_pass++;
            n_total++; if (done_dat_q[i] !== ed) $display("FAIL rr_rdata_%0d: got %h want %h", i, done_dat_q[i], ed); else n_pass++;
            n_total++; if (d - g !== 73) $display("FAIL rr_latency_%0d: got %0d want 73", i, d - g); else n_pass++;
            if (i > 0) begin
                n_total++; if (g - prev_done !== 1) $display("FAIL rr_gap_%0d: got %0d want 1", i, g - prev_done); else n_pass++;
            end
            prev_done = d;
        end
        repeat (100) @(posedge clk100);
        n_total++; if (gnt_cyc_q.size() !== 0) $display("FAIL rr_extra_grant: got %0d want 0", gnt_cyc_q.size()); else n_pass++;
        clear_queues();
    endtask

    task automatic test_withdraw();
        bit ok;
        int ei;
        logic [DW-1:0] ed;
        wdata_i[1*DW +: DW] = 8'h5A;
        exp_idx_q.push_back(1); exp_dat_q.push_back(8'h5A);
        @(posedge clk100); #1 req_i = 3'b010;
        @(posedge clk100); #1 req_i = 3'b000;
        wait_done(1, ok);
        if (!ok) begin n_total++; $display("FAIL withdraw_done_timeout: got none want done"); return; end
        ei = exp_idx_q.pop_front(); ed = exp_dat_q.pop_front();
        n_total++; if (gnt_vec_q.size() < 1 || gnt_vec_q[0] !== NREQ'(1 << ei)) $display("FAIL withdraw_gnt: got %0d grants want one of %b", gnt_vec_q.size(), NREQ'(1 << ei)); else n_pass++;
        n_total++; if (done_vec_q[0] !== NREQ'(1 << ei)) $display("FAIL withdraw_done: got %b want %b", done_vec_q[0], NREQ'(1 << ei)); else n_pass++;
        n_total++; if (done_dat_q[0] !== ed) $display("FAIL withdraw_rdata: got %h want %h", done_dat_q[0], ed); else n_pass++;
        repeat (200) @(posedge clk100);
        n_total++; if (gnt_cyc_q.size() !== 1) $display("FAIL withdraw_regrant: got %0d grants want 1", gnt_cyc_q.size()); else n_pass++;
        n_total++; if (done_cyc_q.size() !== 1) $display("FAIL withdraw_redone: got %0d done want 1", done_cyc_q.size()); else n_pass++;
        clear_queues();
    endtask

    task automatic test_reset_mid();
        bit ok;
        wdata_i[0*DW +: DW] = 8'h96;
        wdata_i[1*DW +: DW] = 8'hC3;
        @(posedge clk100); #1 req_i = 3'b010;
        wait_gnt(1, ok);
        if (!ok) begin n_total++; $display("FAIL rstmid_gnt_timeout: got none want gnt"); req_i = '0; return; end
        n_total++; if (gnt_vec_q[0] !== 3'b010) $display("FAIL rstmid_first_gnt: got %b want 010", gnt_vec_q[0]); else n_pass++;
        repeat (36) @(posedge clk100);
        #1 rst = 1'b1; req_i = '0;
        @(posedge clk100); #1 rst = 1'b0;
        n_total++; if (csn_o !== 3'b111) $display("FAIL rstmid_csn: got %b want 111", csn_o); else n_pass++;
        n_total++; if (sclk_o !== 1'b0) $display("FAIL rstmid_sclk: got %b want 0", sclk_o); else n_pass++;
        n_total++; if (done_o !== 3'b000) $display("FAIL rstmid_done: got %b want 000", done_o); else n_pass++;
        n_total++; if (rdata_o !== 8'h00) $display("FAIL rstmid_rdata: got %h want 00", rdata_o); else n_pass++;
        repeat (150) @(posedge clk100);
        n_total++; if (done_cyc_q.size() !== 0) $display("FAIL rstmid_stale_done: got %0d want 0", done_cyc_q.size()); else n_pass++;
        clear_queues();
        exp_idx_q.push_back(0); exp_dat_q.push_back(8'h96);
        @(posedge clk100); #1 req_i = 3'b111;
        wait_gnt(1, ok);
        if (!ok) begin n_total++; $display("FAIL rstmid_regnt_timeout: got none want gnt"); req_i = '0; return; end
        @(posedge clk100); #1 req_i = '0;
        n_total++; if (gnt_vec_q[0] !== NREQ'(1 << exp_idx_q[0])) $display("FAIL rstmid_fresh_gnt: got %b want %b", gnt_vec_q[0], NREQ'(1 << exp_idx_q[0])); else n_pass++;
        wait_done(1, ok);
        if (!ok) begin n_total++; $display("FAIL rstmid_done_timeout: got none want done"); return; end
        n_total++; if (done_dat_q[0] !== exp_dat_q[0]) $display("FAIL rstmid_fresh_rdata: got %h want %h", done_dat_q[0], exp_dat_q[0]); else n_pass++;
        clear_queues();
    endtask

    task automatic test_miso_div2();
        int g, d;
        bit got;
        logic [DW-1:0] exp2_q[$];
        slave_pat = 8'h3C;
        wdata2 = '0;
        exp2_q.push_back(8'h3C);
        @(posedge clk100); #1 req2 = 3'b001;
        @(negedge clk100);
        g = cyc;
        n_total++; if (gnt2 !== 3'b001) $display("FAIL div2_gnt: got %b want 001", gnt2); else n_pass++;
        @(posedge clk100); #1 req2 = '0;
        got = 1'b0; d = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk100);
            if (done2 != '0) begin got = 1'b1; d = cyc; break; end
        end
        if (!got) begin n_total++; $display("FAIL div2_done_timeout: got none want done"); return; end
        n_total++; if (done2 !== 3'b001) $display("FAIL div2_done_vec: got %b want 001", done2); else n_pass++;
        n_total++; if (d - g !== 37) $display("FAIL div2_latency: got %0d want 37", d - g); else n_pass++;
        n_total++; if (rdata2 !== exp2_q[0]) $display("FAIL div2_rdata: got %h want %h", rdata2, exp2_q[0]); else n_pass++;
        void'(exp2_q.pop_front());
    endtask

    task automatic test_protocol();
        n_total++;
        if (prot_viol !== 0) $display("FAIL protocol_total: got %0d violations want 0", prot_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_reset_mid();
        test_miso_div2();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/spi_arb_master.md
SPI_ARB_MASTER -- requirements
Module: spi_arb_master

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, each owning one chip select.
REQ-002 Parameter DW, default 8: bits per transfer, MSB first.
REQ-003 Parameter HALF_DIV, default 4: clk100 cycles per SCLK half-period; legal range 2..255.
REQ-004 clk100  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i  in  NREQ  per-requester transfer request, level.
REQ-007 wdata_i  in  NREQ*DW  per-requester transmit byte; requester k owns slice [k*DW +: DW].
REQ-008 gnt_o  out  NREQ  one-hot one-cycle pulse marking the requester whose wdata is captured.
REQ-009 done_o  out  NREQ  one-hot one-cycle pulse to the granted requester at transfer end.
REQ-010 rdata_o  out  DW  byte received on miso_i; valid in the done_o cycle, held until the next done_o.
REQ-011 busy_o  out  1  high from the gnt_o cycle through the done_o cycle inclusive.
REQ-012 sclk_o  out  1  SPI clock, mode 0 (idle low).
REQ-013 mosi_o  out  1  SPI data out.
REQ-014 miso_i  in  1  SPI data in, asynchronous to clk100.
REQ-015 csn_o  out  NREQ  active-low chip selects; at most one low at any time.

Function
REQ-016 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-017 IDLE with any req_i high: grant by round-robin, pulse gnt_o, capture wdata slice, go to SETUP; with no request, stay in IDLE.
REQ-018 Round-robin: search starts at index (last granted + 1) mod NREQ; after reset, search starts at index 0.
REQ-019 SETUP: granted csn_o low and mosi_o = captured bit DW-1, held for HALF_DIV cycles, then go to SHIFT.
REQ-020 SHIFT: DW SCLK periods; sclk_o high for HALF_DIV cycles, then low for HALF_DIV cycles.
REQ-021 miso_i SHALL pass through a 2-flop synchronizer and be sampled on the last clk100 cycle of each SCLK high phase.
REQ-022 mosi_o SHALL advance to the next bit on each SCLK falling edge; after the last falling edge it holds bit 0.
REQ-023 HOLD: sclk_o low and csn_o still low for HALF_DIV cycles, then csn_o goes high.
REQ-024 rdata_o updates and done_o pulses in the same cycle, then the FSM goes to GAP.
REQ-025 GAP: all csn_o high for exactly 1 cycle, then go to IDLE.
REQ-026 Length: gnt_o cycle to done_o cycle is 1 + HALF_DIV*(2*DW+2) cycles, which is 73 at the defaults.
REQ-027 Dropping req_i after grant SHALL NOT abort the transfer; a held req_i requests again.
REQ-028 Requests arriving while busy_o is high SHALL wait; the arbiter SHALL NOT queue more than the level of req_i.
REQ-029 If all NREQ requests are held continuously, grants SHALL rotate 0,1,2,0,... with no requester served twice consecutively.
REQ-030 The bit counter SHALL use $clog2(DW+1) bits; the divider counter SHALL use 8 bits and wrap to 0 at HALF_DIV-1.

Reset
REQ-031 rst SHALL force: state IDLE, csn_o all 1, sclk_o 0, mosi_o 0, gnt_o 0, done_o 0, busy_o 0, rdata_o 0, RR pointer 0, synchronizer flops 0.
REQ-032 rst mid-transfer SHALL take effect on the next edge, with no done_o pulse for the aborted transfer.
REQ-033 SPI outputs SHALL be registered and glitch-free.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum type spi_st_t and the DW and NREQ defaults.
REQ-035 The round-robin grant SHALL be a sub-module rr_arb: parameter NREQ; ports clk100, rst, req, adv, gnt.
REQ-036 No other sub-modules; no vendor primitives.

Verification
REQ-037 Single request: req_i=3'b001, wdata=8'hA5, slave loopback -> csn_o[0] only low, MOSI bits 1,0,1,0,0,1,0,1, done_o[0] at gnt+73, rdata_o=8'hA5.
REQ-038 Simultaneous requests: req_i=3'b111 held, wdata 8'h11/22/33 -> grant order 0,1,2,0, one GAP cycle between csn deassert and next gnt_o.
REQ-039 MISO sampling: slave drives 8'h3C, HALF_DIV=2 -> rdata_o=8'h3C, done_o at gnt+37.
REQ-040 Withdrawal: req_i[1] pulsed 1 cycle -> full transfer, single done_o[1], no second grant.
REQ-041 Reset mid-transfer: rst at bit 4 -> next cycle csn_o=3'b111, sclk_o=0, no done_o; fresh request then granted to index 0.
REQ-042 Protocol checker, always on: one-hot csn_o, sclk_o low whenever all csn_o are high, mosi_o stable while sclk_o is high.
